// File: rtl/nco_param_core.sv
// nco_param_core: phase-accumulator NCO with quadrant
// folding, pipelined rotation-mode CORDIC and I/Q output.
module nco_param_core #(
  parameter int PHASE_W = 20,
  parameter int OUT_W   = 12,
  parameter int STAGES  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               fcw_ld,
  input  logic [PHASE_W-1:0] fcw,
  input  logic [PHASE_W-1:0] pofs,
  input  logic               phase_clr,
  input  logic               sel_sign,
  output logic               vld,
  output logic [OUT_W-1:0]   out_x,
  output logic [OUT_W-1:0]   out_y
);

  localparam int ZW  = OUT_W + 4;
  localparam int XW  = OUT_W + 2;
  localparam int AW  = ZW + 2;
  localparam int RW  = PHASE_W - 2;
  localparam int AMP = (1 << (OUT_W - 1)) - 2;

  // atan(2^-i) with pi/2 = 2^30, rescaled so pi/2 = 2^ZW
  function automatic logic [AW-1:0] atan_z(int i);
    longint t;
    case (i)
      0:  t = 536870912;
      1:  t = 316933406;
      2:  t = 167458907;
      3:  t = 85004756;
      4:  t = 42667331;
      5:  t = 21354465;
      6:  t = 10679838;
      7:  t = 5340245;
      8:  t = 2670163;
      9:  t = 1335087;
      10: t = 667544;
      11: t = 333772;
      12: t = 166886;
      13: t = 83443;
      14: t = 41722;
      15: t = 20861;
      default: t = 0;
    endcase
    return AW'((t + (longint'(1) << (29 - ZW))) >> (30 - ZW));
  endfunction

  // round(AMP / K), 1/K held as Q20 per stage count
  function automatic logic [XW-1:0] x0_calc(int n);
    longint ik;
    case (n)
      4:  ik = 638409;
      5:  ik = 637165;
      6:  ik = 636854;
      7:  ik = 636777;
      8:  ik = 636757;
      9:  ik = 636752;
      default: ik = 636751;
    endcase
    return XW'((longint'(AMP) * ik + longint'(524288)) >> 20);
  endfunction

  localparam logic signed [XW-1:0] X0   = x0_calc(STAGES);
  localparam logic signed [XW-1:0] MAXV = XW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [XW-1:0] MINV = -MAXV;
  localparam logic [OUT_W-1:0]     MSB  = {1'b1, {(OUT_W-1){1'b0}}};

  function automatic logic [OUT_W-1:0] sat(
    input logic signed [XW-1:0] v
  );
    logic signed [XW-1:0] t;
    t = v;
    if (v > MAXV)      t = MAXV;
    else if (v < MINV) t = MINV;
    return OUT_W'(t);
  endfunction

  logic [PHASE_W-1:0]   r_acc;
  logic [PHASE_W-1:0]   r_fcw;
  logic [PHASE_W-1:0]   r_p0;
  logic                 r_v0;
  logic signed [XW-1:0] r_x [0:STAGES];
  logic signed [XW-1:0] r_y [0:STAGES];
  logic signed [AW-1:0] r_z [0:STAGES];
  logic [1:0]           r_q [0:STAGES];
  logic [STAGES:0]      r_v;
  logic signed [XW-1:0] w_xn [1:STAGES];
  logic signed [XW-1:0] w_yn [1:STAGES];
  logic signed [AW-1:0] w_zn [1:STAGES];
  logic signed [AW-1:0] w_z0;
  logic signed [XW-1:0] w_mx;
  logic signed [XW-1:0] w_my;
  logic [OUT_W-1:0]     w_sx;
  logic [OUT_W-1:0]     w_sy;
  logic [OUT_W-1:0]     w_fmt;

  // FCW load, accumulator step/clear, phase issue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fcw <= '0;
      r_acc <= '0;
      r_p0  <= '0;
      r_v0  <= 1'b0;
    end else begin
      if (fcw_ld) r_fcw <= fcw;
      if (phase_clr)  r_acc <= '0;
      else if (en)    r_acc <= r_acc + r_fcw;
      r_v0 <= en;
      if (en) r_p0 <= phase_clr ? pofs : r_acc + pofs;
    end
  end

  generate
    if (RW >= ZW) begin : g_trunc
      if (RW > ZW) begin : g_drop
        logic w_unused_lsb;
        assign w_unused_lsb = ^r_p0[RW-ZW-1:0];
      end
      assign w_z0 = {2'b00, r_p0[RW-1 -: ZW]};
    end else begin : g_ext
      assign w_z0 = {2'b00, r_p0[RW-1:0], {(ZW-RW){1'b0}}};
    end
  endgenerate

  for (genvar i = 0; i < STAGES; i++) begin : g_cordic
    localparam logic signed [AW-1:0] ATAN = atan_z(i);
    logic signed [XW-1:0] w_xs;
    logic signed [XW-1:0] w_ys;
    logic                 w_neg;
    assign w_xs  = r_x[i] >>> i;
    assign w_ys  = r_y[i] >>> i;
    assign w_neg = r_z[i][AW-1];
    assign w_xn[i+1] = w_neg ? r_x[i] + w_ys : r_x[i] - w_ys;
    assign w_yn[i+1] = w_neg ? r_y[i] - w_xs : r_y[i] + w_xs;
    assign w_zn[i+1] = w_neg ? r_z[i] + ATAN : r_z[i] - ATAN;
  end

  // Fold into CORDIC seed, then one micro-rotation per stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= STAGES; i++) begin
        r_x[i] <= '0;
        r_y[i] <= '0;
        r_z[i] <= '0;
        r_q[i] <= '0;
      end
      r_v <= '0;
    end else begin
      r_x[0] <= X0;
      r_y[0] <= '0;
      r_z[0] <= w_z0;
      r_q[0] <= r_p0[PHASE_W-1 -: 2];
      for (int i = 1; i <= STAGES; i++) begin
        r_x[i] <= w_xn[i];
        r_y[i] <= w_yn[i];
        r_z[i] <= w_zn[i];
        r_q[i] <= r_q[i-1];
      end
      r_v <= {r_v[STAGES-1:0], r_v0};
    end
  end

  // Quadrant map and symmetric saturation
  always_comb begin
    w_mx = r_x[STAGES];
    w_my = r_y[STAGES];
    unique case (r_q[STAGES])
      2'd0: begin
        w_mx = r_x[STAGES];
        w_my = r_y[STAGES];
      end
      2'd1: begin
        w_mx = -r_y[STAGES];
        w_my = r_x[STAGES];
      end
      2'd2: begin
        w_mx = -r_x[STAGES];
        w_my = -r_y[STAGES];
      end
      2'd3: begin
        w_mx = r_y[STAGES];
        w_my = -r_x[STAGES];
      end
    endcase
    w_sx = sat(w_mx);
    w_sy = sat(w_my);
  end

  assign w_fmt = sel_sign ? '0 : MSB;

  // Output register; holds last sample across bubbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      out_x <= '0;
      out_y <= '0;
    end else begin
      vld <= r_v[STAGES];
      if (r_v[STAGES]) begin
        out_x <= w_sx ^ w_fmt;
        out_y <= w_sy ^ w_fmt;
      end
    end
  end

endmodule

// File: doc/nco_param_core.md
# nco_param_core

Parametrised numerically controlled oscillator core. It generates quadrature outputs cos/sin from a frequency control word using a phase accumulator, quadrant folding, an N-stage pipelined rotation-mode CORDIC and a single output mapper. It is the next-generation NCO for the QPSK prototype and differs from the fixed 20-bit/8-stage board NCO as follows:

- widths and depth are parametrised;
- the block has reset;
- FCW loading is explicit;
- a phase offset input is provided;
- a synchronous phase clear is provided;
- one shared output stage emits X and Y together.

## Interface
Parameters:
- PHASE_W, 20, accumulator, FCW and phase-offset width (16..32)
- OUT_W, 12, output sample width (8..16)
- STAGES, 12, CORDIC iterations (4..16; STAGES ≥ OUT_W for full accuracy)

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  advance accumulator and issue one sample this cycle
- fcw_ld  in  1  load fcw into the FCW register
- fcw  in  PHASE_W  frequency control word (unsigned)
- pofs  in  PHASE_W  phase offset added to the issued phase (unsigned, mod 2^PHASE_W)
- phase_clr  in  1  synchronous accumulator clear
- sel_sign  in  1  1 = two's-complement outputs, 0 = offset binary (MSB inverted)
- vld  out  1  out_x/out_y hold a valid sample
- out_x  out  OUT_W  cosine sample
- out_y  out  OUT_W  sine sample

## Operation

**Reset.** rst_n low clears all of the following asynchronously:
- acc, fcw_q and all pipeline data/valid registers are 0;
- out_x, out_y and vld are 0.

**FCW register.** When fcw_ld = 1, fcw_q ← fcw at the edge. This happens regardless of en. The new value is first used for the increment at the following edge.

**Accumulator.**
- phase_clr = 1: acc ← 0. This has priority over en.
- Otherwise en = 1: acc ← (acc + fcw_q) mod 2^PHASE_W.
- Otherwise acc holds.

**Issue.** When en = 1 and phase_clr = 0, phase p = (acc + pofs) mod 2^PHASE_W is captured into stage 0 with valid = 1. acc here is the pre-increment value.
- If phase_clr = 1 and en = 1, p = pofs (phase 0) is issued.
- en = 0 issues a bubble (valid = 0).

**Fold.**
- q = p[PHASE_W-1:PHASE_W-2].
- r = the remaining bits, an angle in [0, π/2), truncated/extended to the internal angle width OUT_W+4.
- CORDIC starts with x0 = round(A/K), y0 = 0, z0 = r, where A = 2^(OUT_W-1)-2 and K = ∏√(1+2^-2i) over STAGES.
- Internal x/y width is OUT_W+2.

**CORDIC.**
- Stage i uses d = sign(z) and the shift i.
- atan(2^-i) constants are stored as per-stage localparams.
- Arithmetic shifts; no rounding.

**Quadrant map.** For CORDIC result (c, s):
- q0 → (c, s)
- q1 → (−s, c)
- q2 → (−c, −s)
- q3 → (s, −c)

**Output.** Results are saturated to ±(2^(OUT_W-1)-1) and registered. If sel_sign = 0, the MSB is inverted at the output register. sel_sign is sampled at the output stage and is not pipelined with the phase.

**Pipeline.** The pipeline never stalls; there is no backpressure. The valid bit travels with the data.

## Timing
- Latency is STAGES+2 edges. A sample issued at edge k has vld = 1, with its data on out_x/out_y, after edge k+STAGES+2.
- Continuous en gives vld = 1 every cycle after the pipeline fills.
- Bubbles are reproduced exactly STAGES+2 cycles later.
- out_x/out_y hold their last value while vld = 0.
- fcw_ld at edge k changes the phase step of samples issued from edge k+2 onward.
- pofs is applied at issue, so a pofs change affects exactly the samples issued after it.
- Accumulator wrap is silent modular arithmetic; there is no status flag.
- fcw = 0 gives a constant phase and therefore constant outputs.
- Reset mid-stream discards all in-flight samples. vld stays 0 until STAGES+2 edges after the first issue following reset release.
- Accuracy requirement, for STAGES ≥ OUT_W: |out_x − round(A·cos θ)| ≤ 3 LSB and |out_y − round(A·sin θ)| ≤ 3 LSB, where θ = 2π·p/2^PHASE_W.

## Test plan
All scenarios use default parameters: A = 2046 and latency 14.

1. **Reset behaviour.** Reset, then hold en = 0 → out_x = out_y = 0 and vld = 0 indefinitely. Then fcw_ld with fcw = 0, then en = 1 → first vld 14 cycles after the first issue, with out_x = 2046±3 and out_y = 0±3.
2. **Quadrant offsets.** fcw = 0 with pofs of 0x40000, 0x80000 and 0xC0000 → (x, y) = (0, 2046), (−2046, 0) and (0, −2046), each component ±3.
3. **Sweep and period.** fcw = 0x10000 with continuous en → output period of 16 samples; every sample is within ±3 LSB of the ideal values. After 2^20/0x10000 issues the phase wraps to exactly the starting sample.
4. **Bubbles, FCW reload and clear.** Random en pattern → vld equals en delayed by 14. An fcw_ld mid-stream changes the step from the second following issue. phase_clr with en → that sample equals the pofs phase, and subsequent samples restart from 0.
5. **Output format.** sel_sign = 0 at phase 0 → out_x = 2046 ^ 0x800 = 0xFFE and out_y = 0x800. Toggling sel_sign changes the format on the next output edge.
6. **Reset mid-stream.** Assert rst_n low mid-stream → outputs and vld are 0 immediately. No stale sample appears after release.
